match_report_scheduler: RTL and testbench
=========================================

Name: match_report_scheduler

Overview:
- Sequences the back end of the fingerprint-matching datapath.
- Watches the score streams from NUM_FILTERS parallel matched filters for one sweep (capture-buffer replays), tracking each filter's peak signed score.
- At sweep end, picks the winning fingerprint and serializes a report packet to the shared UART byte transmitter.
- Sits between the matched-filter instances and the uart instance, under the filter manager's sweep control.

Parameters:
- NUM_FILTERS, 2, number of matched filters observed (1..15).
- MATCH_SCORE_WIDTH, 32, score width in bits; signed two's complement; multiple of 8.
- REPORT_HEADER, 8'hA5, first byte of every report packet.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sweep_start  input  1  single-cycle pulse: clear peaks, begin tracking
- sweep_done  input  1  single-cycle pulse: last score of sweep has been or is being presented
- score_valid  input  NUM_FILTERS  per-filter score strobe (matched filter axiov)
- score_data  input  NUM_FILTERS*MATCH_SCORE_WIDTH  packed scores, filter i at bits [i*W +: W]
- uart_axiready  input  1  UART idle/ready
- uart_axiiv  output  1  byte strobe to UART
- uart_axiid  output  8  byte to UART
- busy  output  1  high in any state except IDLE
- winner_valid  output  1  single-cycle pulse when winner_id/winner_score update
- winner_id  output  8  index of winning filter; 8'hFF means no score seen
- winner_score  output  MATCH_SCORE_WIDTH  peak score of the winner

Behaviour:
- Reset: state IDLE; uart_axiiv=0, uart_axiid=0, busy=0, winner_valid=0, winner_id=8'hFF, winner_score=0; peaks set to the most negative value; seen flags cleared.
- States: IDLE -> TRACK on sweep_start. TRACK -> SELECT on sweep_done. SELECT -> SEND after NUM_FILTERS cycles. SEND -> IDLE after the last byte is issued.
- TRACK: per filter i, if score_valid[i] and score > peak[i] (signed compare), peak[i] <= score. Set seen[i] on any valid score.
- TRACK with sweep_start again: peaks and seen flags cleared; stays in TRACK.
- TRACK with sweep_done and score_valid in the same cycle: that score is included in the peak.
- Scores arriving outside TRACK are ignored. sweep_start outside IDLE/TRACK is ignored. sweep_done outside TRACK is ignored.
- SELECT: sequential scan, one filter per cycle, index 0 upward. Only filters with seen set compete. Strict greater-than, so ties go to the lowest index.
- SELECT end: if no filter is seen, winner_id=8'hFF and winner_score=0.
- On entering SEND: winner_valid pulses one cycle. winner_id/winner_score hold until the next SELECT completes.
- Latency: sweep_done to winner_valid is NUM_FILTERS+1 cycles.
- Packet order: REPORT_HEADER, winner_id, winner_score most-significant byte first (W/8 bytes), then checksum = 8-bit XOR of all preceding bytes including the header. Total 3+W/8 bytes.
- UART handshake: uart_axiiv pulses high exactly one cycle, with uart_axiid valid that cycle, only when uart_axiready=1 and uart_axiiv was 0 the previous cycle. The byte counter advances on each pulse. No other flow control.
- busy deasserts the cycle after the final byte pulse.
- Reset mid-SEND: uart_axiiv is 0 from the next cycle and no partial-packet completion occurs.
- Byte counter width: $clog2 of the maximum packet length + 1; it does not wrap.

Optional Feature:
- MATCH_REPORT_ALL_SCORES_EN defined: after the winner score and before the checksum, send every filter's peak (index order, MSB first, W/8 bytes each). Unseen filters send 0. The checksum covers these bytes. Packet length is 3+(1+NUM_FILTERS)*W/8.
- Undefined: packet exactly as described in Behaviour.

Decomposition:
- Shared package match_pkg holds:
  - state enum (IDLE, TRACK, SELECT, SEND)
  - REPORT_NO_WINNER = 8'hFF
  - default REPORT_HEADER
  - function returning the most negative value for MATCH_SCORE_WIDTH
- One sub-module, report_serializer: takes a flat byte-vector snapshot plus length, returns done; owns the UART handshake and XOR checksum.
- Peak tracking and selection stay in the top module.

Test Plan:
- Basic win: sweep_start; filter0 scores 10,50,20; filter1 scores -5,70; sweep_done -> winner_valid after 3 cycles, winner_id=1, winner_score=70. UART bytes A5,01,00,00,00,46,E2.
- Tie: both filters peak at 100 -> winner_id=0, bytes A5,00,00,00,00,64,C1.
- All negative: filter0 peak -3 (FFFFFFFD), filter1 peak -9 -> winner_id=0, winner_score=32'hFFFFFFFD.
- No scores: sweep_start then sweep_done -> winner_id=FF, winner_score=0, bytes A5,FF,00,00,00,00,5A.
- Handshake: hold uart_axiready low 20 cycles in SEND -> no uart_axiiv. When released, strobes are never on consecutive cycles; score_valid during SEND leaves the next report unaffected.
- Reset mid-packet: assert rst after the 3rd byte -> uart_axiiv=0 and busy=0 next cycle, winner_id=FF. A new sweep then reports correctly.

Source files
------------

// File: rtl/match_pkg.sv
// Shared FSM states, report constants and score helpers for the match report scheduler.
package match_pkg;

    typedef enum logic [1:0] {IDLE, TRACK, SELECT, SEND} state_e;

    localparam logic [7:0] REPORT_NO_WINNER      = 8'hFF;
    localparam logic [7:0] DEFAULT_REPORT_HEADER = 8'hA5;
    localparam int         MAX_SCORE_WIDTH       = 256;

    // Only the low 'width' bits are meaningful; callers truncate.
    function automatic logic [MAX_SCORE_WIDTH-1:0] most_negative(input int width);
        return MAX_SCORE_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/report_serializer.sv
// Streams a fixed byte vector to the UART one strobe at a time, then appends the XOR checksum.
module report_serializer #(
    parameter int NUM_BYTES = 6,
    parameter int CNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_BYTES*8-1:0] pkt_bytes,
    input  logic [CNT_W-1:0]       pkt_len,
    input  logic                   uart_axiready,
    output logic                   uart_axiiv,
    output logic [7:0]             uart_axiid,
    output logic                   done
);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       csum_q, csum_d;
    logic             iv_q, iv_d;
    logic [7:0]       id_q, id_d;
    logic             last_q, last_d;
    logic [7:0]       cur_byte;
    logic             is_csum;
    logic             fire;

    always_comb begin
        is_csum  = (cnt_q == pkt_len);
        cur_byte = csum_q;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (!is_csum && cnt_q == CNT_W'(k)) cur_byte = pkt_bytes[k*8 +: 8];
        end
        // A strobe is never followed directly by another one.
        fire     = active_q && uart_axiready && !iv_q;

        active_d = active_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        iv_d     = 1'b0;
        id_d     = id_q;
        last_d   = 1'b0;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            csum_d   = '0;
        end else if (fire) begin
            iv_d   = 1'b1;
            id_d   = cur_byte;
            csum_d = csum_q ^ cur_byte;
            cnt_d  = cnt_q + CNT_W'(1);
            last_d = is_csum;
            if (is_csum) active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            csum_q   <= '0;
            iv_q     <= 1'b0;
            id_q     <= '0;
            last_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            iv_q     <= iv_d;
            id_q     <= id_d;
            last_q   <= last_d;
        end
    end

    assign uart_axiiv = iv_q;
    assign uart_axiid = id_q;
    assign done       = iv_q && last_q;

endmodule

// File: rtl/match_report_scheduler.sv
// Tracks per-filter peak scores over a sweep, picks the winner and sends a UART report.
// Define MATCH_REPORT_ALL_SCORES_EN to append every filter's peak before the checksum.
module match_report_scheduler
    import match_pkg::*;
#(
    parameter int         NUM_FILTERS       = 2,
    parameter int         MATCH_SCORE_WIDTH = 32,
    parameter logic [7:0] REPORT_HEADER     = DEFAULT_REPORT_HEADER
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sweep_start,
    input  logic                                   sweep_done,
    input  logic [NUM_FILTERS-1:0]                 score_valid,
    input  logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] score_data,
    input  logic                                   uart_axiready,
    output logic                                   uart_axiiv,
    output logic [7:0]                             uart_axiid,
    output logic                                   busy,
    output logic                                   winner_valid,
    output logic [7:0]                             winner_id,
    output logic [MATCH_SCORE_WIDTH-1:0]           winner_score
);

    localparam int W  = MATCH_SCORE_WIDTH;
    localparam int NF = NUM_FILTERS;
    localparam int SB = W / 8;
`ifdef MATCH_REPORT_ALL_SCORES_EN
    localparam int PAYLOAD_LEN = 2 + (1 + NF) * SB;
`else
    localparam int PAYLOAD_LEN = 2 + SB;
`endif
    localparam int PKT_LEN = PAYLOAD_LEN + 1;
    localparam int CNT_W   = $clog2(PKT_LEN + 1);
    localparam int IDX_W   = $clog2(NF + 1);
    localparam logic [MAX_SCORE_WIDTH-1:0] NEG_FULL = most_negative(W);
    localparam logic [W-1:0]               NEG_PEAK = NEG_FULL[W-1:0];

    state_e                  state_q, state_d;
    logic [NF-1:0][W-1:0]    peak_q, peak_d;
    logic [NF-1:0]           seen_q, seen_d;
    logic [IDX_W-1:0]        scan_q, scan_d;
    logic                    best_found_q, best_found_d;
    logic [7:0]              best_id_q, best_id_d;
    logic [W-1:0]            best_score_q, best_score_d;
    logic [7:0]              winner_id_q, winner_id_d;
    logic [W-1:0]            winner_score_q, winner_score_d;
    logic                    winner_valid_q, winner_valid_d;
    logic                    busy_q, busy_d;

    logic                    cand_seen, take, nxt_found;
    logic [W-1:0]            cand_score, nxt_score;
    logic [7:0]              nxt_id;
    logic [PAYLOAD_LEN*8-1:0] pkt_bytes;
    logic                    send_done;

    always_comb begin
        cand_seen  = 1'b0;
        cand_score = '0;
        for (int i = 0; i < NF; i++) begin
            if (scan_q == IDX_W'(i)) begin
                cand_seen  = seen_q[i];
                cand_score = peak_q[i];
            end
        end
        // Strict compare during the upward scan gives ties to the lowest index.
        take      = cand_seen && (!best_found_q || $signed(cand_score) > $signed(best_score_q));
        nxt_found = best_found_q | take;
        nxt_id    = take ? 8'(scan_q) : best_id_q;
        nxt_score = take ? cand_score : best_score_q;

        state_d        = state_q;
        peak_d         = peak_q;
        seen_d         = seen_q;
        scan_d         = scan_q;
        best_found_d   = best_found_q;
        best_id_d      = best_id_q;
        best_score_d   = best_score_q;
        winner_id_d    = winner_id_q;
        winner_score_d = winner_score_q;
        winner_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = TRACK;
                    peak_d  = {NF{NEG_PEAK}};
                    seen_d  = '0;
                end
            end
            TRACK: begin
                if (sweep_start) begin
                    peak_d = {NF{NEG_PEAK}};
                    seen_d = '0;
                end else begin
                    for (int i = 0; i < NF; i++) begin
                        if (score_valid[i]) begin
                            seen_d[i] = 1'b1;
                            if ($signed(score_data[i*W +: W]) > $signed(peak_q[i]))
                                peak_d[i] = score_data[i*W +: W];
                        end
                    end
                    if (sweep_done) begin
                        state_d      = SELECT;
                        scan_d       = '0;
                        best_found_d = 1'b0;
                    end
                end
            end
            SELECT: begin
                best_found_d = nxt_found;
                best_id_d    = nxt_id;
                best_score_d = nxt_score;
                scan_d       = scan_q + IDX_W'(1);
                if (scan_q == IDX_W'(NF - 1)) begin
                    state_d        = SEND;
                    winner_valid_d = 1'b1;
                    winner_id_d    = nxt_found ? nxt_id : REPORT_NO_WINNER;
                    winner_score_d = nxt_found ? nxt_score : '0;
                end
            end
            SEND: begin
                if (send_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            peak_q         <= {NF{NEG_PEAK}};
            seen_q         <= '0;
            scan_q         <= '0;
            best_found_q   <= 1'b0;
            best_id_q      <= '0;
            best_score_q   <= '0;
            winner_id_q    <= REPORT_NO_WINNER;
            winner_score_q <= '0;
            winner_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            peak_q         <= peak_d;
            seen_q         <= seen_d;
            scan_q         <= scan_d;
            best_found_q   <= best_found_d;
            best_id_q      <= best_id_d;
            best_score_q   <= best_score_d;
            winner_id_q    <= winner_id_d;
            winner_score_q <= winner_score_d;
            winner_valid_q <= winner_valid_d;
            busy_q         <= busy_d;
        end
    end

    // Payload is held stable through SEND: winner regs only change at SELECT end
    // and peaks only change in TRACK.
    always_comb begin
        pkt_bytes        = '0;
        pkt_bytes[7:0]   = REPORT_HEADER;
        pkt_bytes[15:8]  = winner_id_q;
        for (int b = 0; b < SB; b++)
            pkt_bytes[(2+b)*8 +: 8] = winner_score_q[(SB-1-b)*8 +: 8];
`ifdef MATCH_REPORT_ALL_SCORES_EN
        for (int f = 0; f < NF; f++)
            for (int b = 0; b < SB; b++)
                pkt_bytes[(2+SB+f*SB+b)*8 +: 8] = seen_q[f] ? peak_q[f][(SB-1-b)*8 +: 8] : 8'h00;
`endif
    end

    report_serializer #(
        .NUM_BYTES (PAYLOAD_LEN),
        .CNT_W     (CNT_W)
    ) u_serializer (
        .clk           (clk),
        .rst           (rst),
        .start         (winner_valid_q),
        .pkt_bytes     (pkt_bytes),
        .pkt_len       (CNT_W'(PAYLOAD_LEN)),
        .uart_axiready (uart_axiready),
        .uart_axiiv    (uart_axiiv),
        .uart_axiid    (uart_axiid),
        .done          (send_done)
    );

    assign busy         = busy_q;
    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;
    assign winner_score = winner_score_q;

endmodule

// File: tb/tb_match_report_scheduler.sv
// Directed and randomized sweeps against a queue-based packet model of the report scheduler.
module tb_match_report_scheduler;

    localparam int NF = 2;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sweep_start = 1'b0;
    logic            sweep_done = 1'b0;
    logic [NF-1:0]   score_valid = '0;
    logic [NF*W-1:0] score_data = '0;
    logic            uart_axiready = 1'b1;
    logic            uart_axiiv;
    logic [7:0]      uart_axiid;
    logic            busy;
    logic            winner_valid;
    logic [7:0]      winner_id;
    logic [W-1:0]    winner_score;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         consec_err = 0;
    int         last_iv_cyc = 0;
    logic       prev_iv = 1'b0;
    logic [7:0] rx[$];
    logic [7:0] exp_b[$];
    bit         v_tab[64][NF];
    int         d_tab[64][NF];
    int         ncyc;
    logic [7:0] exp_id;
    logic [W-1:0] exp_score;

    match_report_scheduler #(.NUM_FILTERS(NF), .MATCH_SCORE_WIDTH(W), .REPORT_HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .sweep_start(sweep_start), .sweep_done(sweep_done),
        .score_valid(score_valid), .score_data(score_data), .uart_axiready(uart_axiready),
        .uart_axiiv(uart_axiiv), .uart_axiid(uart_axiid), .busy(busy),
        .winner_valid(winner_valid), .winner_id(winner_id), .winner_score(winner_score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_axiiv) begin
            rx.push_back(uart_axiid);
            if (prev_iv) consec_err++;
            last_iv_cyc = cyc;
        end
        prev_iv = uart_axiiv;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int c, input bit v0, input int d0, input bit v1, input int d1);
        v_tab[c][0] = v0; d_tab[c][0] = d0;
        v_tab[c][1] = v1; d_tab[c][1] = d1;
    endtask

    // Reference: peak = max of presented scores, winner = lowest index holding the max.
    task automatic compute_model();
        longint pk[NF];
        bit     sn[NF];
        longint best;
        logic [7:0] cs;
        for (int f = 0; f < NF; f++) begin sn[f] = 0; pk[f] = 0; end
        for (int c = 0; c < ncyc; c++)
            for (int f = 0; f < NF; f++)
                if (v_tab[c][f]) begin
                    if (!sn[f] || longint'(d_tab[c][f]) > pk[f]) pk[f] = d_tab[c][f];
                    sn[f] = 1;
                end
        exp_id = 8'hFF; exp_score = '0; best = 0;
        for (int f = 0; f < NF; f++)
            if (sn[f] && (exp_id == 8'hFF || pk[f] > best)) begin
                exp_id = 8'(f); best = pk[f]; exp_score = pk[f][W-1:0];
            end
        exp_b.delete();
        exp_b.push_back(8'hA5);
        exp_b.push_back(exp_id);
        for (int b = W/8 - 1; b >= 0; b--) exp_b.push_back(exp_score[b*8 +: 8]);
        cs = 8'h00;
        foreach (exp_b[i]) cs = cs ^ exp_b[i];
        exp_b.push_back(cs);
    endtask

    task automatic start_sweep(input bit idle_junk);
        int lat;
        if (idle_junk) begin
            score_valid = '1; score_data = {NF{32'h7FFFFFFF}};
            tick();
            score_valid = '0;
        end
        rx.delete();
        sweep_start = 1'b1; tick(); sweep_start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            for (int f = 0; f < NF; f++) begin
                score_valid[f] = v_tab[c][f];
                score_data[f*W +: W] = d_tab[c][f];
            end
            sweep_done = (c == ncyc - 1);
            tick();
        end
        if (ncyc == 0) begin sweep_done = 1'b1; tick(); end
        sweep_done = 1'b0; score_valid = '0;
        compute_model();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (winner_valid) begin lat = k; break; end
        end
        chk("latency", 64'(lat), 64'(NF + 1));
        chk("winner_id", 64'(winner_id), 64'(exp_id));
        chk("winner_score", 64'(winner_score), 64'(exp_score));
        @(negedge clk);
        chk("winner_valid_pulse", 64'(winner_valid), 64'd0);
    endtask

    task automatic finish_send(input bit rnd_ready, input bit junk);
        bit done = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (!busy) begin done = 1; break; end
            @(posedge clk); #1;
            uart_axiready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin score_valid = NF'($urandom); score_data = {$urandom, $urandom}; end
        end
        uart_axiready = 1'b1; score_valid = '0;
        chk("send_done", 64'(done), 64'd1);
        chk("busy_gap", 64'(cyc - last_iv_cyc), 64'd1);
        chk("pkt_len", 64'(rx.size()), 64'(exp_b.size()));
        foreach (exp_b[i])
            chk($sformatf("byte%0d", i), (i < rx.size()) ? 64'(rx[i]) : 64'hDEAD, 64'(exp_b[i]));
        chk("no_back_to_back", 64'(consec_err), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_iv", 64'(uart_axiiv), 64'd0);
        chk("rst_id", 64'(uart_axiid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wv", 64'(winner_valid), 64'd0);
        chk("rst_wid", 64'(winner_id), 64'hFF);
        chk("rst_wscore", 64'(winner_score), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        sweep_done = 1'b1; tick(); sweep_done = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", 64'(busy), 64'd0);

        // basic win
        ncyc = 3;
        set_row(0, 1, 10, 1, -5); set_row(1, 1, 50, 1, 70); set_row(2, 1, 20, 0, 0);
        start_sweep(1); finish_send(0, 0);
        chk("basic_csum", 64'(rx.size() > 6 ? rx[6] : 8'h00), 64'hE2);

        // tie, last score arrives with sweep_done
        ncyc = 1; set_row(0, 1, 100, 1, 100);
        start_sweep(0); finish_send(0, 0);
        chk("tie_csum", 64'(rx.size() > 6 ? rx[6] : 8'h00), 64'hC1);

        // all negative
        ncyc = 2; set_row(0, 1, -3, 1, -9); set_row(1, 1, -20, 0, 0);
        start_sweep(1); finish_send(0, 0);
        chk("neg_score", 64'(winner_score), 64'hFFFFFFFD);

        // no scores
        ncyc = 0;
        start_sweep(0); finish_send(0, 0);
        chk("none_csum", 64'(rx.size() > 6 ? rx[6] : 8'h00), 64'h5A);

        // handshake: ready held low, junk scores and a stray sweep_start during SEND
        ncyc = 2; set_row(0, 1, 7, 1, 3); set_row(1, 0, 0, 1, 9);
        uart_axiready = 1'b0;
        start_sweep(0);
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            score_valid = '1; score_data = {32'h7FFFFFFF, 32'h7FFFFFFF};
            sweep_start = (t == 5);
        end
        score_valid = '0; sweep_start = 1'b0;
        @(negedge clk);
        chk("hold_no_iv", 64'(rx.size()), 64'd0);
        finish_send(0, 1);

        // reset after the third byte
        ncyc = 1; set_row(0, 1, 33, 1, 44);
        start_sweep(0);
        for (int t = 0; t < 100; t++) begin
            if (rx.size() >= 3) break;
            @(negedge clk);
        end
        chk("rst_reach3", 64'(rx.size()), 64'd3);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_iv", 64'(uart_axiiv), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wid", 64'(winner_id), 64'hFF);
        repeat (10) @(negedge clk);
        chk("midrst_no_more", 64'(rx.size()), 64'd3);

        // randomized sweeps
        for (int it = 0; it < 12; it++) begin
            ncyc = $urandom_range(0, 8);
            for (int c = 0; c < ncyc; c++)
                for (int f = 0; f < NF; f++) begin
                    v_tab[c][f] = 1'($urandom_range(0, 1));
                    d_tab[c][f] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                             : int'($urandom_range(0, 20)) - 10;
                end
            start_sweep(1);
            finish_send(1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
